// File: rtl/alu_ctl_sequencer_pkg.sv
// alu_ctl_pkg: opcodes, mux selects, control beat type and base-op decode for the ALU control sequencer
package alu_ctl_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;
  localparam int COMPOUND_BIT = 3;
  localparam logic [2:0] MUX_ADDSUB = 3'd0;
  localparam logic [2:0] MUX_XOR    = 3'd1;
  localparam logic [2:0] MUX_SLT    = 3'd2;
  localparam logic [2:0] MUX_AND    = 3'd3;
  localparam logic [2:0] MUX_OR     = 3'd4;
  typedef struct packed {
    logic [2:0] muxindex;
    logic       invertB;
    logic       setFlag;
    logic       secondaryOperation;
  } ctl_beat_t;
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} seq_state_t;
  function automatic ctl_beat_t op_decode(input logic [2:0] base_op);
    case (base_op)
      OP_ADD:  return '{MUX_ADDSUB, 1'b0, 1'b1, 1'b0};
      OP_SUB:  return '{MUX_ADDSUB, 1'b1, 1'b1, 1'b0};
      OP_XOR:  return '{MUX_XOR,    1'b0, 1'b0, 1'b0};
      OP_SLT:  return '{MUX_SLT,    1'b1, 1'b0, 1'b0};
      OP_AND:  return '{MUX_AND,    1'b0, 1'b0, 1'b0};
      OP_NAND: return '{MUX_AND,    1'b0, 1'b0, 1'b1};
      OP_NOR:  return '{MUX_OR,     1'b0, 1'b0, 1'b1};
      default: return '{MUX_OR,     1'b0, 1'b0, 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/alu_ctl_sequencer_if.sv
// alu_ctl_sequencer_if: command and control-beat handshake bundle between issue logic, sequencer and datapath
interface alu_ctl_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [3:0]               ALUCommand;
  logic                     ctl_valid;
  logic                     ctl_ready;
  logic [2:0]               muxindex;
  logic                     invertB;
  logic                     setFlag;
  logic                     secondaryOperation;
  logic                     ctl_last;
  logic [TAG_W-1:0]         ctl_tag;
  logic [$clog2(DEPTH):0]   fifo_count;
  modport master (
    output cmd_valid, ALUCommand, ctl_ready,
    input  cmd_ready, ctl_valid, muxindex, invertB, setFlag, secondaryOperation, ctl_last, ctl_tag, fifo_count
  );
  modport slave (
    input  cmd_valid, ALUCommand, ctl_ready,
    output cmd_ready, ctl_valid, muxindex, invertB, setFlag, secondaryOperation, ctl_last, ctl_tag, fifo_count
  );
endinterface

// File: rtl/alu_ctl_sequencer_fifo.sv
// alu_ctl_fifo: synchronous-write command FIFO with occupancy count and combinational head read
module alu_ctl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  assign dout  = mem[rd_q];
  assign count = count_q;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  // pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and occupancy state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset: only slots behind the write pointer are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/alu_ctl_sequencer.sv
// alu_ctl_sequencer: buffers ALU commands and emits registered control beats; ALU_CTL_PERF_EN adds beat/stall counters
module alu_ctl_sequencer
  import alu_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic reset,
  alu_ctl_sequencer_if.slave bus
`ifdef ALU_CTL_PERF_EN
  ,
  output logic [31:0] beat_count,
  output logic [31:0] stall_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic push, pop, full, empty, hs;
  logic [TAG_W+3:0] head;
  logic [CW-1:0] count;
  seq_state_t state_q, state_d;
  ctl_beat_t beat_q, beat_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [TAG_W-1:0] tag_q, tag_d, tagc_q, tagc_d;
  logic [2:0] pend_q, pend_d;
  assign push = bus.cmd_valid && !full;
  assign hs   = valid_q && bus.ctl_ready;
  // refill the output register when idle or when the final beat of a command retires
  assign pop  = !empty && (state_q == IDLE || (hs && last_q));
  assign bus.cmd_ready          = !full;
  assign bus.fifo_count         = count;
  assign bus.ctl_valid          = valid_q;
  assign bus.muxindex           = beat_q.muxindex;
  assign bus.invertB            = beat_q.invertB;
  assign bus.setFlag            = beat_q.setFlag;
  assign bus.secondaryOperation = beat_q.secondaryOperation;
  assign bus.ctl_last           = last_q;
  assign bus.ctl_tag            = tag_q;
  alu_ctl_fifo #(.DEPTH(DEPTH), .WIDTH(4 + TAG_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({tagc_q, bus.ALUCommand}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // next beat: new command from the FIFO, second half of a compound, or drop to idle with zeroed outputs
  always_comb begin
    tagc_d  = push ? tagc_q + 1'b1 : tagc_q;
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    tag_d   = tag_q;
    pend_d  = pend_q;
    if (pop) begin
      state_d = BEAT1;
      valid_d = 1'b1;
      tag_d   = head[TAG_W+3:4];
      pend_d  = head[2:0];
      last_d  = !head[COMPOUND_BIT];
      beat_d  = op_decode(head[COMPOUND_BIT] ? OP_SUB : head[2:0]);
    end else if (hs && !last_q) begin
      state_d = BEAT2;
      beat_d  = op_decode(pend_q);
      last_d  = 1'b1;
    end else if (hs) begin
      state_d = IDLE;
      valid_d = 1'b0;
      beat_d  = '0;
      last_d  = 1'b0;
      tag_d   = '0;
    end
  end
  // registered FSM state and control outputs; reset aborts any in-flight command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      tag_q   <= '0;
      tagc_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      tagc_q  <= tagc_d;
      pend_q  <= pend_d;
    end
  end
`ifdef ALU_CTL_PERF_EN
  logic [31:0] beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;
  assign beat_count  = beat_cnt_q;
  assign stall_count = stall_cnt_q;
  // saturating counters of retired beats and backpressured cycles
  always_comb begin
    beat_cnt_d  = (hs && ~&beat_cnt_q) ? beat_cnt_q + 1'b1 : beat_cnt_q;
    stall_cnt_d = (valid_q && !bus.ctl_ready && ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  // performance counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_ctl_sequencer.sv
// tb_alu_ctl_sequencer: scoreboard bench for alu_ctl_sequencer with directed and random command streams
module tb_alu_ctl_sequencer;
  import alu_ctl_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  typedef struct packed {
    logic [5:0]       dec;
    logic             last;
    logic [TAG_W-1:0] tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_ctl_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
`ifdef ALU_CTL_PERF_EN
  logic [31:0] beat_count, stall_count;
`endif
  alu_ctl_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ALU_CTL_PERF_EN
    ,
    .beat_count  (beat_count),
    .stall_count (stall_count)
`endif
  );
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int tag_model = 0;
  int beats_seen = 0;
  int stalls_seen = 0;
  bit done = 0;
  // reference decode table: {mux, invB, flag, sec}
  function automatic logic [5:0] ref_dec(input logic [2:0] op);
    case (op)
      3'd0: return 6'b000_0_1_0;
      3'd1: return 6'b000_1_1_0;
      3'd2: return 6'b001_0_0_0;
      3'd3: return 6'b010_1_0_0;
      3'd4: return 6'b011_0_0_0;
      3'd5: return 6'b011_0_0_1;
      3'd6: return 6'b100_0_0_1;
      default: return 6'b100_0_0_0;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic expect_cmd(input logic [3:0] c);
    if (c[3]) sb.push_back({ref_dec(3'd1), 1'b0, TAG_W'(tag_model)});
    sb.push_back({ref_dec(c[2:0]), 1'b1, TAG_W'(tag_model)});
    tag_model = (tag_model + 1) % (1 << TAG_W);
  endtask
  task automatic send(input logic [3:0] c, input int budget, output bit ok);
    ok = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.ALUCommand = c;
    for (int i = 0; i < budget && !ok; i++) begin
      if (i > 0) @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      if (ok) expect_cmd(c);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic send_ok(input logic [3:0] c);
    bit ok;
    send(c, 200, ok);
    check("accept", 32'(ok), 32'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !bus.ctl_valid) break;
    end
    check("drain_queue", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(bus.ctl_valid), 32'd0);
  endtask
  // monitor: compare each handshaked beat with the scoreboard and watch backpressure stability
  initial begin
    exp_t cur, prev_cur, e;
    bit prev_stall;
    prev_stall = 0;
    prev_cur = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_stall = 0;
        beats_seen = 0;
        stalls_seen = 0;
        continue;
      end
      cur = {bus.muxindex, bus.invertB, bus.setFlag, bus.secondaryOperation, bus.ctl_last, bus.ctl_tag};
      if (bus.ctl_valid) begin
        if (prev_stall) check("hold_stable", 32'(cur), 32'(prev_cur));
        if (bus.ctl_ready) begin
          beats_seen++;
          prev_stall = 0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h required none at %0t", cur, $time);
          end else begin
            e = sb.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
        end else begin
          stalls_seen++;
          prev_stall = 1;
          prev_cur = cur;
        end
      end else begin
        if (prev_stall) check("hold_valid", 32'(bus.ctl_valid), 32'd1);
        check("idle_zero", 32'(cur), 32'd0);
        prev_stall = 0;
      end
    end
  end
  initial begin
    bit ok;
    bus.cmd_valid = 1'b0;
    bus.ALUCommand = '0;
    bus.ctl_ready = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_ctl_valid", 32'(bus.ctl_valid), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_outputs", 32'({bus.muxindex, bus.invertB, bus.setFlag, bus.secondaryOperation, bus.ctl_last, bus.ctl_tag}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.ctl_ready = 1'b1;
    for (int c = 0; c < 8; c++) send_ok(4'(c));
    drain();
    send_ok(4'b1011);
    drain();
    @(negedge clk);
    bus.ctl_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_ok(4'($urandom));
    @(negedge clk);
    #1;
    check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
    check("full_ready", 32'(bus.cmd_ready), 32'd0);
    send(4'($urandom), 3, ok);
    check("overflow_reject", 32'(ok), 32'd0);
    @(negedge clk);
    bus.ctl_ready = 1'b1;
    drain();
    for (int i = 0; i < (1 << TAG_W) + 1; i++) send_ok({1'b0, 3'($urandom)});
    drain();
    @(negedge clk);
    bus.ctl_ready = 1'b0;
    send_ok(4'b1101);
    for (int i = 0; i < 3; i++) send_ok(4'($urandom));
    @(negedge clk);
    #1;
    check("mid_valid", 32'(bus.ctl_valid), 32'd1);
    check("mid_last", 32'(bus.ctl_last), 32'd0);
    check("mid_count", 32'(bus.fifo_count), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("async_valid", 32'(bus.ctl_valid), 32'd0);
    check("async_count", 32'(bus.fifo_count), 32'd0);
    check("async_ready", 32'(bus.cmd_ready), 32'd1);
    sb.delete();
    tag_model = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.ctl_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("no_stale", 32'(bus.ctl_valid), 32'd0);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_ok(4'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          bus.ctl_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    bus.ctl_ready = 1'b1;
    drain();
    check("end_count", 32'(bus.fifo_count), 32'd0);
`ifdef ALU_CTL_PERF_EN
    check("perf_beats", beat_count, 32'(beats_seen));
    check("perf_stalls", stall_count, 32'(stalls_seen));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
